traffic_fsm_multi: RTL and testbench

Parametrised successor to the two-road light-controller FSM. It sequences green, extension, yellow and walk phases across `N_APPR` approaches. Approach 0 is the main road and is always served; side approaches are served only on latched sensor demand. It drives the same external interval timer through a `start_timer`/`interval`/`expired` handshake and clears the external walk-request register through `WR_Reset`.

---
 rtl/traffic_pkg.sv | 31 +++
 rtl/traffic_next_appr.sv | 34 +++
 rtl/traffic_fsm_multi.sv | 133 +++++++++++++
 tb/tb_traffic_fsm_multi.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and constants for the multi-approach light controller.
//   state_e      - controller phase
//   INT_*        - timer interval select codes driven on `interval`
//   N_APPR_MAX   - largest supported approach count
//   state2ival() - interval code that belongs to a phase
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN_BASE = 2'd0,
    GREEN_EXT  = 2'd1,
    YELLOW     = 2'd2,
    WALK       = 2'd3
  } state_e;

  localparam logic [1:0] INT_BASE = 2'b00;
  localparam logic [1:0] INT_EXT  = 2'b01;
  localparam logic [1:0] INT_YEL  = 2'b10;
  localparam logic [1:0] INT_WALK = 2'b11;

  localparam int N_APPR_MAX = 4;

  function automatic logic [1:0] state2ival(input state_e s);
    case (s)
      GREEN_BASE: state2ival = INT_BASE;
      GREEN_EXT:  state2ival = INT_EXT;
      YELLOW:     state2ival = INT_YEL;
      default:    state2ival = INT_WALK;
    endcase
  endfunction

endpackage

// File: rtl/traffic_next_appr.sv
// traffic_next_appr: rotate-priority picker for the next approach to serve.
//   cur_i - approach currently served
//   dem_i - latched side-road demand (bit 0 ignored, approach 0 always eligible)
//   nxt_o - first index after cur_i, in cyclic order, with demand or equal to 0
module traffic_next_appr
  import traffic_pkg::*;
#(
  parameter int N_APPR = 3,
  parameter int AW     = $clog2(N_APPR)
) (
  input  logic [AW-1:0]     cur_i,
  input  logic [N_APPR-1:0] dem_i,
  output logic [AW-1:0]     nxt_o
);

  int            idx;
  logic [AW-1:0] idx_t;

  // Scan farthest-first so the nearest eligible candidate is the final winner.
  // Approach 0 always qualifies, so the scan can never come up empty.
  always_comb begin
    nxt_o = '0;
    idx   = 0;
    idx_t = '0;
    for (int k = N_APPR_MAX - 1; k >= 1; k--) begin
      if (k < N_APPR) begin
        idx   = (int'(cur_i) + k) % N_APPR;
        idx_t = AW'(idx);
        if (idx == 0 || dem_i[idx_t]) nxt_o = idx_t;
      end
    end
  end

endmodule

// File: rtl/traffic_fsm_multi.sv
// traffic_fsm_multi: green / extension / yellow / walk sequencer over N_APPR approaches.
// Approach 0 (main road) is always served; side roads only on latched sensor demand.
//   clk, Reset_Sync   - clock, async active-high reset
//   Prog_Sync         - synchronous restart to GREEN_BASE of approach 0
//   Sensor_Sync       - per-approach vehicle sensors
//   WR, WR_Reset      - walk request in, one-cycle clear of the walk latch out
//   expired, start_timer, interval - external interval-timer handshake
//   green, yellow, walk, cur_appr  - registered lamp outputs and served approach
module traffic_fsm_multi
  import traffic_pkg::*;
#(
  parameter int N_APPR = 3,
  parameter int AW     = $clog2(N_APPR)
) (
  input  logic              clk,
  input  logic              Reset_Sync,
  input  logic              Prog_Sync,
  input  logic [N_APPR-1:0] Sensor_Sync,
  input  logic              WR,
  input  logic              expired,
  output logic              start_timer,
  output logic [1:0]        interval,
  output logic              WR_Reset,
  output logic [N_APPR-1:0] green,
  output logic [N_APPR-1:0] yellow,
  output logic              walk,
  output logic [AW-1:0]     cur_appr
);

  state_e            state_q, state_d;
  logic [AW-1:0]     cur_q, cur_d, nxt;
  logic [N_APPR-1:0] dem_q, dem_d;
  logic [N_APPR-1:0] green_q, green_d, yellow_q, yellow_d, oh;
  logic              start_q, start_d, wrr_q, wrr_d, walk_q, walk_d;
  logic [1:0]        ival_q, ival_d;
  logic              init_q;  // high until the first edge after reset: timer not yet started
  logic              adv;

  traffic_next_appr #(.N_APPR(N_APPR), .AW(AW)) u_next (
    .cur_i (cur_q),
    .dem_i (dem_q),
    .nxt_o (nxt)
  );

  // An expiry seen while start_timer is high belongs to the previous interval.
  // Every advance issues a new start, so a held level steps once per start.
  assign adv = expired & ~start_q & ~init_q;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    dem_d   = dem_q;
    start_d = 1'b0;
    wrr_d   = 1'b0;

    for (int j = 1; j < N_APPR; j++)
      if (Sensor_Sync[j] && !green_q[j]) dem_d[j] = 1'b1;
    dem_d[0] = 1'b0;

    if (Prog_Sync) begin
      state_d = GREEN_BASE;
      cur_d   = '0;
      dem_d   = '0;
      start_d = 1'b1;
    end else if (init_q) begin
      start_d = 1'b1;
    end else if (adv) begin
      start_d = 1'b1;
      case (state_q)
        GREEN_BASE: state_d = Sensor_Sync[cur_q] ? GREEN_EXT : YELLOW;
        GREEN_EXT:  state_d = YELLOW;
        YELLOW: begin
          if (WR) begin
            state_d = WALK;
            wrr_d   = 1'b1;
          end else begin
            state_d    = GREEN_BASE;
            cur_d      = nxt;
            dem_d[nxt] = 1'b0;  // entry clear beats a same-cycle sensor set
          end
        end
        default: begin
          state_d    = GREEN_BASE;
          cur_d      = nxt;
          dem_d[nxt] = 1'b0;
        end
      endcase
    end

    // Lamps are decoded from the next state so they register with the transition.
    oh        = '0;
    oh[cur_d] = 1'b1;
    green_d   = (state_d == GREEN_BASE || state_d == GREEN_EXT) ? oh : '0;
    yellow_d  = (state_d == YELLOW) ? oh : '0;
    walk_d    = (state_d == WALK);
    ival_d    = state2ival(state_d);
  end

  always_ff @(posedge clk or posedge Reset_Sync) begin
    if (Reset_Sync) begin
      state_q  <= GREEN_BASE;
      cur_q    <= '0;
      dem_q    <= '0;
      start_q  <= 1'b0;
      wrr_q    <= 1'b0;
      green_q  <= N_APPR'(1);
      yellow_q <= '0;
      walk_q   <= 1'b0;
      ival_q   <= INT_BASE;
      init_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      dem_q    <= dem_d;
      start_q  <= start_d;
      wrr_q    <= wrr_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      walk_q   <= walk_d;
      ival_q   <= ival_d;
      init_q   <= 1'b0;
    end
  end

  assign start_timer = start_q;
  assign interval    = ival_q;
  assign WR_Reset    = wrr_q;
  assign green       = green_q;
  assign yellow      = yellow_q;
  assign walk        = walk_q;
  assign cur_appr    = cur_q;

endmodule

// File: tb/tb_traffic_fsm_multi.sv
// Directed bench for traffic_fsm_multi with N_APPR=3.
module tb_traffic_fsm_multi;

  localparam int N = 3;

  logic         clk, Reset_Sync, Prog_Sync, WR, expired;
  logic [N-1:0] Sensor_Sync;
  logic         start_timer, WR_Reset, walk;
  logic [1:0]   interval;
  logic [N-1:0] green, yellow;
  logic [1:0]   cur_appr;

  int nvec = 0;
  int nmis = 0;

  traffic_fsm_multi #(.N_APPR(N)) dut (
    .clk         (clk),
    .Reset_Sync  (Reset_Sync),
    .Prog_Sync   (Prog_Sync),
    .Sensor_Sync (Sensor_Sync),
    .WR          (WR),
    .expired     (expired),
    .start_timer (start_timer),
    .interval    (interval),
    .WR_Reset    (WR_Reset),
    .green       (green),
    .yellow      (yellow),
    .walk        (walk),
    .cur_appr    (cur_appr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nvec++;
    if (obs !== exp_v) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic lamps(input string tag, input logic [2:0] g, input logic [2:0] y,
                       input logic w, input logic [1:0] iv, input logic st,
                       input logic wrr, input logic [1:0] cur);
    chk({tag, ".green"},  32'(green),       32'(g));
    chk({tag, ".yellow"}, 32'(yellow),      32'(y));
    chk({tag, ".walk"},   32'(walk),        32'(w));
    chk({tag, ".ival"},   32'(interval),    32'(iv));
    chk({tag, ".start"},  32'(start_timer), 32'(st));
    chk({tag, ".wrrst"},  32'(WR_Reset),    32'(wrr));
    chk({tag, ".cur"},    32'(cur_appr),    32'(cur));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // From a start_timer cycle: idle one cycle, then pulse expired for one cycle.
  // Returns in the start_timer cycle of the following phase.
  task automatic adv_once;
    tick();
    expired = 1'b1;
    tick();
    expired = 1'b0;
  endtask

  initial begin
    Reset_Sync = 1'b1; Prog_Sync = 1'b0; WR = 1'b0; expired = 1'b0; Sensor_Sync = '0;
    #12;
    lamps("rst", 3'b001, 3'b000, 0, 2'b00, 0, 0, 2'd0);
    @(negedge clk);
    Reset_Sync = 1'b0;
    tick();
    lamps("g0_first", 3'b001, 3'b000, 0, 2'b00, 1, 0, 2'd0);

    // No demand: main road alternates green/yellow
    adv_once(); lamps("y0_a", 3'b000, 3'b001, 0, 2'b10, 1, 0, 2'd0);
    adv_once(); lamps("g0_a", 3'b001, 3'b000, 0, 2'b00, 1, 0, 2'd0);

    // Demand on approach 2 only: 1 is skipped
    tick(); Sensor_Sync = 3'b100; tick(); Sensor_Sync = '0;
    chk("g0_hold.start", 32'(start_timer), 32'd0);
    adv_once(); lamps("y0_b", 3'b000, 3'b001, 0, 2'b10, 1, 0, 2'd0);
    adv_once(); lamps("g2",   3'b100, 3'b000, 0, 2'b00, 1, 0, 2'd2);
    adv_once(); lamps("y2",   3'b000, 3'b100, 0, 2'b10, 1, 0, 2'd2);
    adv_once(); lamps("g0_b", 3'b001, 3'b000, 0, 2'b00, 1, 0, 2'd0);
    // dem[2] was consumed: next cycle returns straight to approach 0
    adv_once(); lamps("y0_c", 3'b000, 3'b001, 0, 2'b10, 1, 0, 2'd0);
    adv_once(); lamps("g0_c", 3'b001, 3'b000, 0, 2'b00, 1, 0, 2'd0);

    // Extension on main road, only once
    Sensor_Sync = 3'b001;
    adv_once(); lamps("ext0", 3'b001, 3'b000, 0, 2'b01, 1, 0, 2'd0);
    adv_once(); lamps("y0_ext", 3'b000, 3'b001, 0, 2'b10, 1, 0, 2'd0);
    Sensor_Sync = '0;
    adv_once(); lamps("g0_d", 3'b001, 3'b000, 0, 2'b00, 1, 0, 2'd0);

    // Walk after yellow
    adv_once(); lamps("y0_w", 3'b000, 3'b001, 0, 2'b10, 1, 0, 2'd0);
    WR = 1'b1;
    adv_once(); lamps("walk", 3'b000, 3'b000, 1, 2'b11, 1, 1, 2'd0);
    WR = 1'b0;
    tick(); lamps("walk_hold", 3'b000, 3'b000, 1, 2'b11, 0, 0, 2'd0);
    adv_once(); lamps("g0_w", 3'b001, 3'b000, 0, 2'b00, 1, 0, 2'd0);

    // expired held high: one step per start
    expired = 1'b1;
    tick(); lamps("lvl_g0", 3'b001, 3'b000, 0, 2'b00, 0, 0, 2'd0);
    tick(); lamps("lvl_y0", 3'b000, 3'b001, 0, 2'b10, 1, 0, 2'd0);
    tick(); lamps("lvl_y0h", 3'b000, 3'b001, 0, 2'b10, 0, 0, 2'd0);
    tick(); lamps("lvl_g0b", 3'b001, 3'b000, 0, 2'b00, 1, 0, 2'd0);
    expired = 1'b0;

    // Prog during YELLOW1 with expired and a fresh sensor on 2
    tick(); Sensor_Sync = 3'b010; tick(); Sensor_Sync = '0;
    adv_once(); lamps("y0_p", 3'b000, 3'b001, 0, 2'b10, 1, 0, 2'd0);
    adv_once(); lamps("g1",   3'b010, 3'b000, 0, 2'b00, 1, 0, 2'd1);
    adv_once(); lamps("y1",   3'b000, 3'b010, 0, 2'b10, 1, 0, 2'd1);
    tick();
    Prog_Sync = 1'b1; expired = 1'b1; Sensor_Sync = 3'b100;
    tick();
    Prog_Sync = 1'b0; expired = 1'b0; Sensor_Sync = '0;
    lamps("prog", 3'b001, 3'b000, 0, 2'b00, 1, 0, 2'd0);
    adv_once(); lamps("y0_pp", 3'b000, 3'b001, 0, 2'b10, 1, 0, 2'd0);
    adv_once(); lamps("g0_pp", 3'b001, 3'b000, 0, 2'b00, 1, 0, 2'd0);

    // Asynchronous reset during WALK
    adv_once();
    WR = 1'b1;
    adv_once(); lamps("walk2", 3'b000, 3'b000, 1, 2'b11, 1, 1, 2'd0);
    WR = 1'b0;
    #2 Reset_Sync = 1'b1;
    #1 lamps("arst", 3'b001, 3'b000, 0, 2'b00, 0, 0, 2'd0);
    tick();
    Reset_Sync = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
